// File: rtl/rf_write_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------------------+
// | rf_write_arbiter: shares one register-file write port between WB and the LLU return.    |
// | The optional starve_events counter is built under `RF_ARB_STARVE_COUNT_EN. Rev 1.0      |
// +----------------------------------------------------------------------------------------+
module rf_write_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             wb_valid,
  input  logic [4:0]       wb_addr,
  input  logic [31:0]      wb_data,
  input  logic             llu_valid,
  input  logic [4:0]       llu_addr,
  input  logic [31:0]      llu_data,
  output logic             llu_ready,
  output logic             stall_pipe,
  output logic [31:0]      rf_addr_rd,
  output logic [31:0]      rf_data_rd,
  output logic             rf_write_enable,
  output logic             grant_src,
  output logic [CNT_W-1:0] starve_events
);

  typedef enum logic [0:0] {
    NORMAL = 1'b0,
    FORCE  = 1'b1
  } state_t;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_t      state;
  state_t      state_next;
  logic [3:0]  wait_cnt;
  logic [3:0]  wait_next;
  logic        grant;
  logic        grant_llu;
  logic [4:0]  grant_addr;
  logic [31:0] grant_data;

  always_comb begin
    state_next = NORMAL;
    wait_next  = '0;
    grant      = 1'b0;
    grant_llu  = 1'b0;
    grant_addr = wb_addr;
    grant_data = wb_data;
    llu_ready  = 1'b0;
    case (state)
      NORMAL: begin
        if (wb_valid) begin
          grant = 1'b1;
          if (llu_valid) begin
            wait_next = wait_cnt + 4'd1;
            if (wait_next == LIMIT) state_next = FORCE;
          end
        end else if (llu_valid) begin
          grant      = 1'b1;
          grant_llu  = 1'b1;
          grant_addr = llu_addr;
          grant_data = llu_data;
          llu_ready  = 1'b1;
        end
      end
      FORCE: begin
        // The WB request is dropped; the stalled pipeline re-presents it next cycle.
        grant      = llu_valid;
        grant_llu  = 1'b1;
        grant_addr = llu_addr;
        grant_data = llu_data;
        llu_ready  = llu_valid;
      end
      default: ;
    endcase
    if (reset) llu_ready = 1'b0;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= NORMAL;
      wait_cnt   <= '0;
      stall_pipe <= 1'b0;
    end else begin
      state      <= state_next;
      wait_cnt   <= wait_next;
      stall_pipe <= (state_next == FORCE);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rf_addr_rd      <= '0;
      rf_data_rd      <= '0;
      rf_write_enable <= 1'b0;
      grant_src       <= 1'b0;
    end else if (grant) begin
      rf_addr_rd      <= {27'b0, grant_addr};
      rf_data_rd      <= grant_data;
      rf_write_enable <= (grant_addr != 5'd0);
      grant_src       <= grant_llu;
    end else begin
      rf_write_enable <= 1'b0;
    end
  end

`ifdef RF_ARB_STARVE_COUNT_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      starve_events <= '0;
    end else if ((state == FORCE) && (starve_events != {CNT_W{1'b1}})) begin
      starve_events <= starve_events + 1'b1;
    end
  end
`else
  assign starve_events = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_rf_write_arbiter.sv
`default_nettype none
// tb_rf_write_arbiter: directed stimulus, behavioural model compared every cycle plus literal checks.
module tb_rf_write_arbiter;

  localparam int LIMIT  = 4;
  localparam int CW     = 4;
  localparam int EV_MAX = (1 << CW) - 1;

  logic          clock = 1'b0;
  logic          reset;
  logic          wb_valid, llu_valid;
  logic [4:0]    wb_addr, llu_addr;
  logic [31:0]   wb_data, llu_data;
  logic          llu_ready, stall_pipe, rf_write_enable, grant_src;
  logic [31:0]   rf_addr_rd, rf_data_rd;
  logic [CW-1:0] starve_events;

  int checks = 0;
  int errors = 0;

  rf_write_arbiter #(.STARVE_LIMIT(LIMIT), .CNT_W(CW)) dut (
    .clock(clock), .reset(reset),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
    .llu_valid(llu_valid), .llu_addr(llu_addr), .llu_data(llu_data),
    .llu_ready(llu_ready), .stall_pipe(stall_pipe),
    .rf_addr_rd(rf_addr_rd), .rf_data_rd(rf_data_rd),
    .rf_write_enable(rf_write_enable), .grant_src(grant_src),
    .starve_events(starve_events)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: count refusals of a waiting LLU result; once the streak hits the
  // limit the next cycle belongs to the LLU, whatever WB wants.
  int          m_streak = 0;
  bit          m_force  = 0;
  int          m_events = 0;
  logic        m_stall = 0, m_we = 0, m_src = 0;
  logic [4:0]  m_addr = 0;
  logic [31:0] m_data = 0;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_streak = 0; m_force = 0; m_events = 0;
      m_stall = 0; m_we = 0; m_src = 0; m_addr = 0; m_data = 0;
    end else begin
      m_we = 0;
      if (m_force) begin
        m_force  = 0;
        m_streak = 0;
        m_events = (m_events >= EV_MAX) ? EV_MAX : m_events + 1;
        if (llu_valid) begin
          m_addr = llu_addr; m_data = llu_data; m_src = 1; m_we = (llu_addr != 0);
        end
      end else if (wb_valid) begin
        m_addr = wb_addr; m_data = wb_data; m_src = 0; m_we = (wb_addr != 0);
        if (llu_valid) begin
          m_streak++;
          if (m_streak == LIMIT) m_force = 1;
        end else begin
          m_streak = 0;
        end
      end else begin
        if (llu_valid) begin
          m_addr = llu_addr; m_data = llu_data; m_src = 1; m_we = (llu_addr != 0);
        end
        m_streak = 0;
      end
      m_stall = m_force;
    end
  end

  function automatic int exp_events(input int ev);
`ifdef RF_ARB_STARVE_COUNT_EN
    return ev;
`else
    return 0;
`endif
  endfunction

  always @(negedge clock) begin
    logic exp_ready;
    exp_ready = reset ? 1'b0 : (m_force ? llu_valid : (!wb_valid && llu_valid));
    check("m_llu_ready", {31'b0, llu_ready}, {31'b0, exp_ready});
    check("m_stall", {31'b0, stall_pipe}, {31'b0, m_stall});
    check("m_we", {31'b0, rf_write_enable}, {31'b0, m_we});
    check("m_addr", rf_addr_rd, {27'b0, m_addr});
    check("m_data", rf_data_rd, m_data);
    check("m_src", {31'b0, grant_src}, {31'b0, m_src});
    check("m_events", {{(32-CW){1'b0}}, starve_events}, 32'(exp_events(m_events)));
  end

  task automatic drive(input logic wv, input logic [4:0] wa, input logic [31:0] wd,
                       input logic lv, input logic [4:0] la, input logic [31:0] ld);
    wb_valid = wv; wb_addr = wa; wb_data = wd;
    llu_valid = lv; llu_addr = la; llu_data = ld;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    drive(0, 0, 0, 1, 5'd3, 32'h1);
    tick(); tick();
    check("rst_ready", {31'b0, llu_ready}, 32'd0);
    check("rst_we", {31'b0, rf_write_enable}, 32'd0);
    check("rst_addr", rf_addr_rd, 32'd0);
    check("rst_events", {{(32-CW){1'b0}}, starve_events}, 32'd0);
    drive(0, 0, 0, 0, 0, 0);
    reset = 1'b0;
    tick();

    // Plain WB write
    drive(1, 5'd5, 32'hDEADBEEF, 0, 0, 0);
    tick();
    check("wb_we", {31'b0, rf_write_enable}, 32'd1);
    check("wb_addr", rf_addr_rd, 32'd5);
    check("wb_data", rf_data_rd, 32'hDEADBEEF);
    check("wb_src", {31'b0, grant_src}, 32'd0);
    check("wb_stall", {31'b0, stall_pipe}, 32'd0);

    // LLU write on an idle WB cycle
    drive(0, 0, 0, 1, 5'd7, 32'h12345678);
    #2 check("llu_ready", {31'b0, llu_ready}, 32'd1);
    tick();
    check("llu_addr", rf_addr_rd, 32'd7);
    check("llu_data", rf_data_rd, 32'h12345678);
    check("llu_src", {31'b0, grant_src}, 32'd1);

    // Starvation: four WB grants, then a forced LLU grant
    drive(1, 5'd3, 32'h11, 1, 5'd9, 32'hA5A5A5A5);
    for (int i = 0; i < LIMIT; i++) begin
      #2 check("starve_ready_lo", {31'b0, llu_ready}, 32'd0);
      tick();
      check("starve_stall", {31'b0, stall_pipe}, (i == LIMIT - 1) ? 32'd1 : 32'd0);
    end
    #2 check("force_ready", {31'b0, llu_ready}, 32'd1);
    tick();
    check("force_stall_off", {31'b0, stall_pipe}, 32'd0);
    check("force_we", {31'b0, rf_write_enable}, 32'd1);
    check("force_addr", rf_addr_rd, 32'd9);
    check("force_src", {31'b0, grant_src}, 32'd1);
    check("force_events", {{(32-CW){1'b0}}, starve_events}, 32'(exp_events(1)));
    drive(0, 0, 0, 0, 0, 0);
    tick();

    // Writes to x0 are suppressed but still handshake
    drive(1, 5'd0, 32'hFFFFFFFF, 0, 0, 0);
    tick();
    check("x0_wb_we", {31'b0, rf_write_enable}, 32'd0);
    drive(0, 0, 0, 1, 5'd0, 32'h55);
    #2 check("x0_llu_ready", {31'b0, llu_ready}, 32'd1);
    tick();
    check("x0_llu_we", {31'b0, rf_write_enable}, 32'd0);
    drive(0, 0, 0, 0, 0, 0);
    tick();

    // Asynchronous reset in the middle of a FORCE cycle
    drive(1, 5'd2, 32'h22, 1, 5'd12, 32'hCAFEF00D);
    repeat (LIMIT) tick();
    check("pre_rst_stall", {31'b0, stall_pipe}, 32'd1);
    #2 reset = 1'b1;
    #1;
    check("arst_stall", {31'b0, stall_pipe}, 32'd0);
    check("arst_we", {31'b0, rf_write_enable}, 32'd0);
    check("arst_events", {{(32-CW){1'b0}}, starve_events}, 32'd0);
    check("arst_ready", {31'b0, llu_ready}, 32'd0);
    tick();
    drive(0, 0, 0, 1, 5'd12, 32'hCAFEF00D);
    reset = 1'b0;
    #2 check("post_rst_ready", {31'b0, llu_ready}, 32'd1);
    tick();
    check("post_rst_addr", rf_addr_rd, 32'd12);
    check("post_rst_we", {31'b0, rf_write_enable}, 32'd1);

    // Seventeen forced grants saturate a 4-bit counter
    drive(1, 5'd4, 32'h44, 1, 5'd13, 32'h13);
    repeat (17 * (LIMIT + 1)) tick();
    check("sat_events", {{(32-CW){1'b0}}, starve_events}, 32'(exp_events(EV_MAX)));
    drive(0, 0, 0, 0, 0, 0);
    tick(); tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rf_write_arbiter.md
Name: rf_write_arbiter

Overview:
- Shares the register file's single write port between two requesters:
  - the pipeline writeback stage (WB);
  - the long-latency unit return path (LLU: loads and mul/div results).
- WB normally has priority. Anti-starvation logic forces an LLU grant by stalling the pipeline for one cycle.
- Sits between the WB stage / LLU and the register file write port (addr_rd, data_rd, write_enable).

Parameters:
- STARVE_LIMIT, 4, consecutive cycles a valid LLU request may be refused before a forced grant (legal range 1..15).
- CNT_W, 16, width of the starvation event counter.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- wb_valid  in  1  WB stage presents a register write this cycle.
- wb_addr  in  5  WB destination register.
- wb_data  in  32  WB write data.
- llu_valid  in  1  LLU presents a result; held stable until accepted.
- llu_addr  in  5  LLU destination register.
- llu_data  in  32  LLU result data.
- llu_ready  out  1  LLU result accepted this cycle (combinational).
- stall_pipe  out  1  pipeline must hold all stages; the WB request is not taken (registered).
- rf_addr_rd  out  32  register file write address, zero-extended from 5 bits (registered).
- rf_data_rd  out  32  register file write data (registered).
- rf_write_enable  out  1  register file write strobe (registered).
- grant_src  out  1  source of the last registered write: 0 = WB, 1 = LLU.
- starve_events  out  CNT_W  number of forced grants, saturating.

Behaviour:
- Reset: asynchronous, active-high; the clock is single.
  - All outputs go to 0: stall_pipe, rf_addr_rd, rf_data_rd, rf_write_enable, grant_src, starve_events.
  - llu_ready reads 0 while reset is asserted.
  - state = NORMAL, wait_cnt = 0.
- State machine: NORMAL, FORCE.
- NORMAL:
  - wb_valid=1: grant WB; llu_ready=0. If llu_valid=1, wait_cnt increments.
  - wb_valid=0, llu_valid=1: grant LLU; llu_ready=1; wait_cnt cleared.
  - llu_valid=0: wait_cnt cleared.
  - At the edge where the increment makes wait_cnt == STARVE_LIMIT: next state = FORCE, stall_pipe <= 1.
- FORCE (exactly one cycle):
  - stall_pipe=1; grant LLU regardless of wb_valid; llu_ready=llu_valid.
  - WB request is ignored; the pipeline re-presents it next cycle.
  - Next state = NORMAL; stall_pipe <= 0; wait_cnt <= 0; starve_events increments and saturates at all-ones.
  - If llu_valid=0 in FORCE (protocol violation): no write, the stall is still spent, return to NORMAL.
- Write port, one-cycle latency. At the clock edge after a grant:
  - rf_addr_rd <= {27'b0, addr}; rf_data_rd <= data; grant_src <= source.
  - rf_write_enable <= 1 only if addr != 0.
  - A write to x0 completes its handshake (llu_ready still 1) but produces rf_write_enable=0.
- No grant in a cycle:
  - rf_write_enable <= 0.
  - rf_addr_rd, rf_data_rd and grant_src hold their values.
- Same-rd conflict: write order equals grant order. A younger WB write granted before a stalled older LLU result for the same rd is a pipeline-level hazard, handled upstream.
- Reset mid-FORCE: state returns to NORMAL immediately. A pending LLU request remains valid and is re-arbitrated after reset.

Optional Feature:
- Macro: RF_ARB_STARVE_COUNT_EN.
- Defined: starve_events counts as described above.
- Undefined: the counter register is not built, and starve_events is tied to 0.
- Arbitration and stall behaviour are identical in both builds.

Test Plan:
- Reset, then wb_valid=1, wb_addr=5, wb_data=0xDEADBEEF -> next cycle rf_write_enable=1, rf_addr_rd=5, rf_data_rd=0xDEADBEEF, grant_src=0, stall_pipe=0.
- wb_valid=0, llu_valid=1, llu_addr=7, llu_data=0x12345678 -> llu_ready=1 the same cycle; next cycle write to 7 with grant_src=1.
- STARVE_LIMIT=4; wb_valid=1 and llu_valid=1 held continuously:
  - WB granted for 4 cycles, with llu_ready=0;
  - 5th cycle: stall_pipe=1, llu_ready=1;
  - following cycle: LLU write lands, stall_pipe=0, starve_events=1 (0 if RF_ARB_STARVE_COUNT_EN is undefined).
- wb_valid=1, wb_addr=0, wb_data=0xFFFFFFFF -> next cycle rf_write_enable=0. llu_valid=1, llu_addr=0 with wb idle -> llu_ready=1, rf_write_enable=0.
- Reset asserted asynchronously during the FORCE cycle -> stall_pipe=0, rf_write_enable=0, starve_events=0 immediately. After release, LLU granted when wb_valid=0.
- Starvation event counter: with CNT_W=4 and RF_ARB_STARVE_COUNT_EN defined, force 17 starvation events -> starve_events stops at 0xF.
